// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
//   mem_op_t    : memory operation encoding from execute
//   mem_size_t  : access size encoding (byte/half/word/dword)
//   mem_state_t : stage FSM states
//   be_base()   : unshifted byte-enable mask for an access size
//   misaligned(): offset is not a multiple of the access size
package mem_pkg;

    localparam int unsigned DATA_SIZE    = 64;
    localparam int unsigned ADDR_SIZE    = 64;
    localparam int unsigned REG_IDX_BITS = 5;
    localparam int unsigned OFFSET_BITS  = 3;
    localparam int unsigned BE_BITS      = 8;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_t;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2,
        MEM_D = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

    localparam logic [BE_BITS-1:0] BE_BASE_B = 8'h01;
    localparam logic [BE_BITS-1:0] BE_BASE_H = 8'h03;
    localparam logic [BE_BITS-1:0] BE_BASE_W = 8'h0F;
    localparam logic [BE_BITS-1:0] BE_BASE_D = 8'hFF;

    function automatic logic [BE_BITS-1:0] be_base(input mem_size_t size);
        case (size)
            MEM_B:   be_base = BE_BASE_B;
            MEM_H:   be_base = BE_BASE_H;
            MEM_W:   be_base = BE_BASE_W;
            default: be_base = BE_BASE_D;
        endcase
    endfunction

    function automatic logic misaligned(input mem_size_t size,
                                        input logic [OFFSET_BITS-1:0] offset);
        case (size)
            MEM_B:   misaligned = 1'b0;
            MEM_H:   misaligned = offset[0];
            MEM_W:   misaligned = |offset[1:0];
            default: misaligned = |offset;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load data alignment and extension (combinational).
//   rdata      : aligned 64-bit memory word
//   offset     : byte offset of the access within the word
//   size       : access size
//   is_unsigned: zero-extend instead of sign-extend
//   data       : lane-shifted, truncated and extended load value
module mem_load_ext
    import mem_pkg::*;
(
    input  logic [DATA_SIZE-1:0]   rdata,
    input  logic [OFFSET_BITS-1:0] offset,
    input  mem_size_t              size,
    input  logic                   is_unsigned,
    output logic [DATA_SIZE-1:0]   data
);

    logic [DATA_SIZE-1:0] shifted;
    logic                 ext_bit;

    // Bring the addressed byte lane down to bit 0, then extend by size.
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        ext_bit = 1'b0;
        data    = shifted;
        case (size)
            MEM_B: begin
                ext_bit = ~is_unsigned & shifted[7];
                data    = {{56{ext_bit}}, shifted[7:0]};
            end
            MEM_H: begin
                ext_bit = ~is_unsigned & shifted[15];
                data    = {{48{ext_bit}}, shifted[15:0]};
            end
            MEM_W: begin
                ext_bit = ~is_unsigned & shifted[31];
                data    = {{32{ext_bit}}, shifted[31:0]};
            end
            default: begin
                ext_bit = 1'b0;
                data    = shifted;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage following the execute ALU.
// Issues loads/stores on a req/gnt/rvalid port, aligns/extends load data and
// presents a single registered writeback beat. Stalls execute while busy.
// Optional: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses (mem_exc)
// instead of issuing them with truncated lanes.
// Ports:
//   clk, rst_n                    : clock, async active-low reset
//   ex_valid / ex_ready           : handshake with execute
//   ex_alu_result, ex_store_data  : result/address and store data
//   ex_mem_op, ex_mem_size,
//   ex_mem_unsigned, ex_rd,
//   ex_reg_write                  : instruction control fields
//   dmem_req/we/addr/be/wdata     : memory request (held until dmem_gnt)
//   dmem_gnt, dmem_rvalid,
//   dmem_rdata                    : memory response
//   wb_valid/rd/reg_write/data    : writeback beat (one-cycle pulse)
//   mem_exc                       : misaligned-access exception pulse
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned DATA_SIZE    = mem_pkg::DATA_SIZE,
    parameter int unsigned ADDR_SIZE    = mem_pkg::ADDR_SIZE,
    parameter int unsigned REG_IDX_BITS = mem_pkg::REG_IDX_BITS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ex_valid,
    output logic                    ex_ready,
    input  logic [DATA_SIZE-1:0]    ex_alu_result,
    input  logic [DATA_SIZE-1:0]    ex_store_data,
    input  logic [1:0]              ex_mem_op,
    input  logic [1:0]              ex_mem_size,
    input  logic                    ex_mem_unsigned,
    input  logic [REG_IDX_BITS-1:0] ex_rd,
    input  logic                    ex_reg_write,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [ADDR_SIZE-1:0]    dmem_addr,
    output logic [7:0]              dmem_be,
    output logic [DATA_SIZE-1:0]    dmem_wdata,
    input  logic                    dmem_gnt,
    input  logic                    dmem_rvalid,
    input  logic [DATA_SIZE-1:0]    dmem_rdata,
    output logic                    wb_valid,
    output logic [REG_IDX_BITS-1:0] wb_rd,
    output logic                    wb_reg_write,
    output logic [DATA_SIZE-1:0]    wb_data,
    output logic                    mem_exc
);

    mem_state_t              state;
    mem_size_t               size_q;
    logic                    unsigned_q;
    logic [OFFSET_BITS-1:0]  offset_q;
    logic [REG_IDX_BITS-1:0] rd_q;
    logic                    reg_write_q;

    logic                    accept;
    logic                    is_mem;
    logic                    is_store;
    logic                    trap;
    mem_size_t               ex_size;
    logic [OFFSET_BITS-1:0]  ex_offset;
    logic [7:0]              ex_be;
    logic [DATA_SIZE-1:0]    ex_wdata;
    logic [DATA_SIZE-1:0]    load_data;

    assign ex_ready = (state == IDLE);

    // Decode of the incoming instruction; reserved op 3 behaves as none.
    always_comb begin
        accept    = ex_valid && (state == IDLE);
        is_store  = (ex_mem_op == MEM_STORE);
        is_mem    = (ex_mem_op == MEM_LOAD) || is_store;
        ex_size   = mem_size_t'(ex_mem_size);
        ex_offset = ex_alu_result[OFFSET_BITS-1:0];
        ex_be     = be_base(ex_size) << ex_offset;
        ex_wdata  = ex_store_data << {ex_offset, 3'b000};
`ifdef MEM_MISALIGN_TRAP_EN
        trap      = is_mem && misaligned(ex_size, ex_offset);
`else
        trap      = 1'b0;
`endif
    end

    mem_load_ext u_load_ext (
        .rdata       (dmem_rdata),
        .offset      (offset_q),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .data        (load_data)
    );

    // Stage FSM with registered memory-port and writeback outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            size_q       <= MEM_B;
            unsigned_q   <= 1'b0;
            offset_q     <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= '0;
            dmem_wdata   <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            wb_data      <= '0;
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        size_q      <= ex_size;
                        unsigned_q  <= ex_mem_unsigned;
                        offset_q    <= ex_offset;
                        rd_q        <= ex_rd;
                        reg_write_q <= ex_reg_write;
                        if (trap) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= ex_rd;
                        end else if (is_mem) begin
                            state      <= REQ;
                            dmem_req   <= 1'b1;
                            dmem_we    <= is_store;
                            dmem_addr  <= {ex_alu_result[ADDR_SIZE-1:OFFSET_BITS], 3'b000};
                            dmem_be    <= ex_be;
                            dmem_wdata <= ex_wdata;
                        end else begin
                            wb_valid     <= 1'b1;
                            wb_rd        <= ex_rd;
                            wb_reg_write <= ex_reg_write;
                            wb_data      <= ex_alu_result;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        if (dmem_we) begin
                            state    <= IDLE;
                            wb_valid <= 1'b1;
                            wb_rd    <= rd_q;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        state        <= IDLE;
                        wb_valid     <= 1'b1;
                        wb_rd        <= rd_q;
                        wb_reg_write <= reg_write_q;
                        wb_data      <= load_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // Exception pulse accompanies the trap writeback beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_exc <= 1'b0;
        end else begin
            mem_exc <= accept && trap;
        end
    end
`else
    assign mem_exc = 1'b0;
`endif

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute-stage ALU.
- Consumes the 64-bit ALU result, used either as a writeback value or as a load/store effective address.
- Drives a req/gnt/rvalid data-memory port, aligns and extends load data, and presents one registered writeback beat.
- Back-pressures execute while a memory transaction is outstanding.

Parameters:
- DATA_SIZE, 64, datapath and memory word width in bits; must be 64.
- ADDR_SIZE, 64, effective-address width in bits.
- REG_IDX_BITS, 5, destination register index width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  execute presents an instruction
- ex_ready  out  1  stage accepts this cycle; equals (state == IDLE)
- ex_alu_result  in  DATA_SIZE  ALU output: result or effective address
- ex_store_data  in  DATA_SIZE  rs2 value for stores
- ex_mem_op  in  2  0 none, 1 load, 2 store, 3 reserved (treated as none)
- ex_mem_size  in  2  0 byte, 1 half, 2 word, 3 dword
- ex_mem_unsigned  in  1  zero-extend load data (LBU/LHU/LWU)
- ex_rd  in  REG_IDX_BITS  destination register
- ex_reg_write  in  1  instruction writes rd
- dmem_req  out  1  memory request
- dmem_we  out  1  1 store, 0 load
- dmem_addr  out  ADDR_SIZE  effective address with [2:0] cleared
- dmem_be  out  8  byte enables
- dmem_wdata  out  DATA_SIZE  lane-shifted store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  DATA_SIZE  aligned 64-bit load word
- wb_valid  out  1  writeback beat valid (single cycle)
- wb_rd  out  REG_IDX_BITS  writeback register
- wb_reg_write  out  1  write enable, qualified by wb_valid
- wb_data  out  DATA_SIZE  writeback value
- mem_exc  out  1  misaligned-access exception pulse (feature-dependent)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; dmem_req, dmem_we, dmem_be, wb_valid, wb_reg_write, mem_exc = 0; dmem_addr, dmem_wdata, wb_data, wb_rd = 0. A dmem_rvalid arriving after reset release with no outstanding load is ignored.
- Accept: ex_valid && ex_ready. Latch all ex_* fields, plus offset = ex_alu_result[2:0].
- FSM states: IDLE, REQ, WAIT.
- Non-memory op in IDLE: next cycle wb_valid=1, wb_data=ex_alu_result; stay IDLE. Latency 1, throughput 1/cycle.
- Load/store in IDLE: go to REQ.
- REQ: dmem_req=1; address, be, we and wdata held stable until dmem_gnt.
- Store granted: next cycle wb_valid=1, wb_reg_write=0, return to IDLE.
- Load granted: go to WAIT. If dmem_rvalid arrives in the grant cycle it is not sampled; rvalid is only valid strictly after gnt.
- WAIT: on dmem_rvalid, next cycle wb_valid=1 with extended data, then IDLE. Minimum load latency 3 cycles from accept (accept, REQ with gnt, WAIT with rvalid); minimum store latency 2.
- Byte enables: base = {1,3,0xF,0xFF}[size]; dmem_be = (base << offset)[7:0].
- Store data: dmem_wdata = ex_store_data << (8*offset).
- Load data: shifted = dmem_rdata >> (8*offset), truncated to the access size, then sign- or zero-extended to 64 bits. Word loads sign-extend unless ex_mem_unsigned.
- wb_valid is a single-cycle pulse; the writeback stage never back-pressures.
- ex_ready=0 in REQ and WAIT, so upstream holds.
- A dword access with offset != 0 spills lanes beyond byte 7; they are truncated (see Optional Feature).

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: an access whose offset is not a multiple of its size issues no dmem_req. The stage stays IDLE and next cycle pulses mem_exc=1 with wb_valid=1, wb_reg_write=0.
- Undefined: mem_exc tied 0; misaligned accesses proceed with truncated lanes as above.

Decomposition:
- Shared package mem_pkg holds:
  - mem_op_t enum (MEM_NONE, MEM_LOAD, MEM_STORE)
  - mem_size_t enum (MEM_B, MEM_H, MEM_W, MEM_D)
  - mem_state_t (IDLE, REQ, WAIT)
  - byte-enable base constants
- One combinational sub-module, mem_load_ext: inputs rdata, offset, size, unsigned; output the extended 64-bit value.

Test Plan:
- Non-memory op: ex_alu_result=0x1234, rd=5 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5; ex_ready stays 1.
- LB at addr 0x1003, rdata=0x00000000_80FF0000, gnt immediate, rvalid one cycle later -> dmem_be=0x08, dmem_addr=0x1000, wb_data=0xFFFFFFFF_FFFFFF80; LBU same stimulus -> wb_data=0x80.
- SH at 0x2006 with store_data=0xBEEF and gnt delayed 3 cycles -> dmem_be=0xC0, dmem_wdata[63:48]=0xBEEF, req/addr/be stable all 3 cycles, ex_ready=0, one wb_valid with wb_reg_write=0.
- LW at offset 4, rdata[63:32]=0x8000_0001 -> wb_data=0xFFFFFFFF_80000001; LWU -> 0x00000000_80000001.
- rst_n dropped during WAIT -> outputs zero immediately; later rvalid produces no wb_valid; next accepted op completes normally.
- With MEM_MISALIGN_TRAP_EN: LW at 0x1002 -> no dmem_req, mem_exc=1 for one cycle; without the macro -> request issued with dmem_be=0x3C.
